fifo_traffic_gen: RTL and testbench
===================================

// Module: fifo_traffic_gen
// PURPOSE
//  Synthesizable stimulus source driving the write/read side of the synchronous FIFO.
//  Feeds the same FIFO_interface signals that the FIFO monitor samples.
//  Runs selectable traffic modes: fill/drain, random, overflow stress, underflow stress.
//  Keeps saturating accept/flag counters for self-checking, then reports done.
// PARAMETERS
//  FIFO_WIDTH   16        data_in width
//  FIFO_DEPTH   8         FIFO entries; sizes stress bursts (FIFO_DEPTH+2 cycles)
//  NUM_OPS      1000      MIX-state cycles in random mode (1..65535)
//  LFSR_SEED    16'hACE1  reset/start seed of the 16-bit LFSR; must be non-zero
// PORTS
//  clk          in   1           clock, all logic on posedge
//  rst          in   1           synchronous, active-high reset
//  start        in   1           level; begins a run when sampled high in IDLE
//  mode         in   2           00 fill-drain, 01 random, 10 overflow, 11 underflow; latched on start
//  wr_en        out  1           FIFO write request (registered)
//  rd_en        out  1           FIFO read request (registered)
//  data_in      out  FIFO_WIDTH  FIFO write data (registered)
//  full         in   1           FIFO full
//  almostfull   in   1           FIFO count == FIFO_DEPTH-1
//  empty        in   1           FIFO empty
//  almostempty  in   1           FIFO count == 1
//  wr_ack       in   1           FIFO accepted the previous write
//  overflow     in   1           FIFO rejected a write
//  underflow    in   1           FIFO rejected a read
//  busy         out  1           high in FILL/DRAIN/MIX
//  done         out  1           high while in DONE
//  wr_count     out  16          wr_ack pulses seen this run
//  rd_count     out  16          cycles with rd_en=1 and empty=0 this run
//  ovf_count    out  16          overflow pulses seen this run
//  udf_count    out  16          underflow pulses seen this run
// BEHAVIOUR
//  Reset: state IDLE; wr_en, rd_en, busy, done = 0; data_in = 0; all counters = 0.
//   LFSR = LFSR_SEED. Reset mid-run aborts immediately; no residual requests.
//  FSM states: IDLE, FILL, DRAIN, MIX, DONE.
//  IDLE + start: latch mode; clear counters, data counter and op counter; reseed LFSR.
//   Next state and the first request are set on the same edge:
//    mode 00 -> FILL,  wr_en=1
//    mode 01 -> MIX
//    mode 10 -> FILL,  wr_en=1
//    mode 11 -> DRAIN, rd_en=1
//  start is ignored outside IDLE.
//  Mode 00 FILL: next wr_en = !full && !(wr_en && almostfull).
//   This predicts full so the generator never overflows.
//   When full=1 and wr_en=0: go to DRAIN and set rd_en=1.
//  Mode 00 DRAIN: next rd_en = !empty && !(rd_en && almostempty).
//   When empty=1 and rd_en=0: go to DONE.
//  Mode 10 FILL: wr_en held high exactly FIFO_DEPTH+2 cycles, ignoring flags, then DONE.
//  Mode 11 DRAIN: rd_en held high exactly FIFO_DEPTH+2 cycles, ignoring flags, then DONE.
//  Mode 01 MIX: each cycle wr_en <= lfsr[0], rd_en <= lfsr[1]; the LFSR then advances.
//   LFSR polynomial x^16+x^14+x^13+x^11+1, Fibonacci form, shift left.
//   After NUM_OPS cycles: wr_en = rd_en = 0, go to DONE.
//  data_in: incrementing counter, starting at 0 each run.
//   Advances after every cycle in which wr_en=1, accepted or not; wraps modulo 2^FIFO_WIDTH.
//  Counters: update every cycle from the input flags; saturate at 16'hFFFF.
//  DONE: wr_en = rd_en = 0; done = 1; returns to IDLE when start=0.
//   Counters hold until the next start.
//  Simultaneous wr_en and rd_en (MIX) are allowed; FIFO arbitration is not this block's concern.
// TESTING
//  1. Assert rst for 2 cycles mid-MIX -> next cycle all outputs 0, busy=0, state IDLE.
//  2. Mode 00, DEPTH 8 -> 8 writes with data 0..7, then 8 reads.
//     Expect wr_count=8, rd_count=8, ovf_count=0, udf_count=0, done=1.
//  3. Mode 10 on an empty FIFO -> 10 write cycles.
//     Expect wr_count=8, ovf_count=2, last data_in=9.
//  4. Mode 11 on an empty FIFO -> 10 read cycles.
//     Expect rd_count=0, udf_count=10, wr_count=0.
//  5. Mode 01, NUM_OPS=1000 -> busy for exactly 1000 MIX cycles.
//     Expect 0 <= wr_count-rd_count <= 8; two runs with the same seed give identical counts.
//  6. start pulsed while busy -> ignored.
//     After DONE, drop and raise start with mode 00 -> counters cleared, clean second run.

Source files
------------

// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen: synthesizable stimulus source for the write/read side of a synchronous FIFO
// Ports:
//   clk, rst                  clock (posedge) and synchronous active-high reset
//   start, mode               run request (level, sampled in IDLE) and traffic mode
//                             00 fill-drain, 01 random, 10 overflow stress, 11 underflow stress
//   wr_en, rd_en, data_in     registered FIFO requests and write data
//   full, almostfull, empty, almostempty, wr_ack, overflow, underflow   FIFO status inputs
//   busy, done                run in progress / run finished (held until start drops)
//   wr_count, rd_count, ovf_count, udf_count   saturating per-run event counters
module fifo_traffic_gen #(
    parameter int          FIFO_WIDTH = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter int          NUM_OPS    = 1000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  full,
    input  logic                  almostfull,
    input  logic                  empty,
    input  logic                  almostempty,
    input  logic                  wr_ack,
    input  logic                  overflow,
    input  logic                  underflow,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count,
    output logic [15:0]           ovf_count,
    output logic [15:0]           udf_count
);
    localparam logic [15:0] BURST_LAST = 16'(FIFO_DEPTH + 1);
    localparam logic [15:0] OPS_LAST   = 16'(NUM_OPS - 1);

    typedef enum logic [2:0] {IDLE, FILL, DRAIN, MIX, DONE} state_t;

    state_t                r_state, w_state;
    logic                  r_stress, w_stress;
    logic                  r_wr_en, w_wr_en;
    logic                  r_rd_en, w_rd_en;
    logic [FIFO_WIDTH-1:0] r_data, w_data;
    logic [15:0]           r_lfsr, w_lfsr;
    logic [15:0]           r_ops, w_ops;
    logic [15:0]           r_wr_cnt, w_wr_cnt;
    logic [15:0]           r_rd_cnt, w_rd_cnt;
    logic [15:0]           r_ovf_cnt, w_ovf_cnt;
    logic [15:0]           r_udf_cnt, w_udf_cnt;
    logic                  w_fb;

    // x^16+x^14+x^13+x^11+1, Fibonacci, shifting left
    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_comb begin
        w_state   = r_state;
        w_stress  = r_stress;
        w_wr_en   = 1'b0;
        w_rd_en   = 1'b0;
        w_data    = r_data + FIFO_WIDTH'(r_wr_en);
        w_lfsr    = r_lfsr;
        w_ops     = r_ops;
        w_wr_cnt  = (wr_ack && r_wr_cnt != 16'hFFFF) ? r_wr_cnt + 16'd1 : r_wr_cnt;
        w_rd_cnt  = (r_rd_en && !empty && r_rd_cnt != 16'hFFFF) ? r_rd_cnt + 16'd1 : r_rd_cnt;
        w_ovf_cnt = (overflow && r_ovf_cnt != 16'hFFFF) ? r_ovf_cnt + 16'd1 : r_ovf_cnt;
        w_udf_cnt = (underflow && r_udf_cnt != 16'hFFFF) ? r_udf_cnt + 16'd1 : r_udf_cnt;
        case (r_state)
            IDLE: if (start) begin
                w_stress  = mode[1];
                w_data    = '0;
                w_ops     = '0;
                w_lfsr    = LFSR_SEED;
                w_wr_cnt  = '0;
                w_rd_cnt  = '0;
                w_ovf_cnt = '0;
                w_udf_cnt = '0;
                w_state   = (mode == 2'b01) ? MIX : (mode == 2'b11) ? DRAIN : FILL;
                w_wr_en   = !mode[0];
                w_rd_en   = (mode == 2'b11);
            end
            FILL: if (r_stress) begin
                if (r_ops == BURST_LAST) begin
                    w_state = DONE;
                end else begin
                    w_ops   = r_ops + 16'd1;
                    w_wr_en = 1'b1;
                end
            end else if (full && !r_wr_en) begin
                w_state = DRAIN;
                w_rd_en = 1'b1;
            end else begin
                // a write already in flight at almostfull will make the FIFO full
                w_wr_en = !full && !(r_wr_en && almostfull);
            end
            DRAIN: if (r_stress) begin
                if (r_ops == BURST_LAST) begin
                    w_state = DONE;
                end else begin
                    w_ops   = r_ops + 16'd1;
                    w_rd_en = 1'b1;
                end
            end else if (empty && !r_rd_en) begin
                w_state = DONE;
            end else begin
                w_rd_en = !empty && !(r_rd_en && almostempty);
            end
            MIX: if (r_ops == OPS_LAST) begin
                w_state = DONE;
            end else begin
                w_ops   = r_ops + 16'd1;
                w_wr_en = r_lfsr[0];
                w_rd_en = r_lfsr[1];
                w_lfsr  = {r_lfsr[14:0], w_fb};
            end
            DONE: w_state = start ? DONE : IDLE;
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_stress  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_data    <= '0;
            r_lfsr    <= LFSR_SEED;
            r_ops     <= '0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_ovf_cnt <= '0;
            r_udf_cnt <= '0;
        end else begin
            r_state   <= w_state;
            r_stress  <= w_stress;
            r_wr_en   <= w_wr_en;
            r_rd_en   <= w_rd_en;
            r_data    <= w_data;
            r_lfsr    <= w_lfsr;
            r_ops     <= w_ops;
            r_wr_cnt  <= w_wr_cnt;
            r_rd_cnt  <= w_rd_cnt;
            r_ovf_cnt <= w_ovf_cnt;
            r_udf_cnt <= w_udf_cnt;
        end
    end

    assign wr_en     = r_wr_en;
    assign rd_en     = r_rd_en;
    assign data_in   = r_data;
    assign busy      = (r_state == FILL) || (r_state == DRAIN) || (r_state == MIX);
    assign done      = (r_state == DONE);
    assign wr_count  = r_wr_cnt;
    assign rd_count  = r_rd_cnt;
    assign ovf_count = r_ovf_cnt;
    assign udf_count = r_udf_cnt;
endmodule

// File: tb/tb_fifo_traffic_gen.sv
// tb_fifo_traffic_gen: directed self-checking bench with a behavioural 8-deep FIFO
module tb_fifo_traffic_gen;
    localparam int          W    = 16;
    localparam int          D    = 8;
    localparam int          NOPS = 1000;
    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk = 1'b0;
    logic         rst, f_rst, start;
    logic [1:0]   mode;
    logic         wr_en, rd_en, busy, done;
    logic [W-1:0] data_in;
    logic         full, almostfull, empty, almostempty, wr_ack, overflow, underflow;
    logic [15:0]  wr_count, rd_count, ovf_count, udf_count;
    logic [3:0]   f_cnt;

    int checks = 0;
    int errors = 0;
    int n_wr, n_rd, n_busy, first_sum, wc1, rc1;
    logic [W-1:0] last_data, first_data;
    logic got_done;
    logic [W-1:0] dq[$];

    always #5 clk = ~clk;

    fifo_traffic_gen #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .NUM_OPS(NOPS), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
        .full(full), .almostfull(almostfull), .empty(empty), .almostempty(almostempty),
        .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .busy(busy), .done(done),
        .wr_count(wr_count), .rd_count(rd_count), .ovf_count(ovf_count), .udf_count(udf_count)
    );

    // behavioural FIFO: occupancy only, registered status pulses
    assign full        = (f_cnt == 4'(D));
    assign almostfull  = (f_cnt == 4'(D - 1));
    assign empty       = (f_cnt == 4'd0);
    assign almostempty = (f_cnt == 4'd1);

    always @(posedge clk) begin
        if (f_rst) begin
            f_cnt     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_en && !full;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            f_cnt     <= f_cnt + 4'(wr_en && !full) - 4'(rd_en && !empty);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // number of MIX request cycles with the given LFSR bit set
    function automatic int exp_hi(input int b);
        logic [15:0] l = SEED;
        int s = 0;
        for (int k = 0; k < NOPS - 1; k++) begin
            s += int'(l[b]);
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        return s;
    endfunction

    task automatic clear_fifo();
        f_rst = 1'b1;
        @(negedge clk);
        f_rst = 1'b0;
    endtask

    // runs one mode until done, optionally toggling start/mode mid-run; leaves start low
    // and returns one cycle after DONE so the counters include the final status pulse
    task automatic run(input string tag, input logic [1:0] m, input int max, input int glitch);
        mode = m;
        start = 1'b1;
        n_wr = 0;
        n_rd = 0;
        n_busy = 0;
        got_done = 1'b0;
        last_data = '0;
        dq.delete();
        for (int i = 0; i < max && !got_done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                first_sum = int'(wr_count) + int'(rd_count) + int'(ovf_count) + int'(udf_count);
                first_data = data_in;
            end
            if (i == glitch) begin
                start = 1'b0;
                mode = ~m;
            end
            if (i == glitch + 1) start = 1'b1;
            if (wr_en) begin
                n_wr++;
                last_data = data_in;
                dq.push_back(data_in);
            end
            if (rd_en) n_rd++;
            if (busy) n_busy++;
            got_done = done;
        end
        chk({tag, "_done"}, 32'(got_done), 32'd1);
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        f_rst = 1'b1;
        start = 1'b0;
        mode = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        f_rst = 1'b0;
        chk("rst_req", {30'd0, wr_en, rd_en}, 32'd0);
        chk("rst_flags", {30'd0, busy, done}, 32'd0);
        chk("rst_data", 32'(data_in), 32'd0);
        chk("rst_cnt", 32'(wr_count) + 32'(rd_count) + 32'(ovf_count) + 32'(udf_count), 32'd0);

        // reset in the middle of a random run
        mode = 2'b01;
        start = 1'b1;
        repeat (20) @(negedge clk);
        chk("mix_busy", 32'(busy), 32'd1);
        start = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_req", {30'd0, wr_en, rd_en}, 32'd0);
        chk("abort_flags", {30'd0, busy, done}, 32'd0);
        chk("abort_data", 32'(data_in), 32'd0);
        chk("abort_cnt", 32'(wr_count) + 32'(rd_count) + 32'(ovf_count) + 32'(udf_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_after", {29'd0, wr_en, rd_en, busy}, 32'd0);
        clear_fifo();

        // fill then drain
        run("fd", 2'b00, 100, -1);
        chk("fd_nwr", 32'(n_wr), 32'd8);
        chk("fd_nrd", 32'(n_rd), 32'd8);
        chk("fd_wr", 32'(wr_count), 32'd8);
        chk("fd_rd", 32'(rd_count), 32'd8);
        chk("fd_ovf", 32'(ovf_count), 32'd0);
        chk("fd_udf", 32'(udf_count), 32'd0);
        chk("fd_ndata", 32'(dq.size()), 32'd8);
        for (int i = 0; i < dq.size(); i++) chk("fd_data", 32'(dq[i]), 32'(i));

        // underflow stress on the empty FIFO
        run("udf", 2'b11, 100, -1);
        chk("udf_nrd", 32'(n_rd), 32'd10);
        chk("udf_nwr", 32'(n_wr), 32'd0);
        chk("udf_rd", 32'(rd_count), 32'd0);
        chk("udf_udf", 32'(udf_count), 32'd10);
        chk("udf_wr", 32'(wr_count), 32'd0);

        // overflow stress, start dropped and re-raised with another mode mid-run
        run("ovf", 2'b10, 100, 3);
        chk("ovf_nwr", 32'(n_wr), 32'd10);
        chk("ovf_last", 32'(last_data), 32'd9);
        chk("ovf_wr", 32'(wr_count), 32'd8);
        chk("ovf_ovf", 32'(ovf_count), 32'd2);
        chk("ovf_rd", 32'(rd_count) + 32'(udf_count), 32'd0);
        chk("ovf_level", 32'(f_cnt), 32'd8);

        // random traffic, twice from the same seed
        clear_fifo();
        run("mix1", 2'b01, NOPS + 100, -1);
        chk("mix_cycles", 32'(n_busy), 32'(NOPS));
        chk("mix_nwr", 32'(n_wr), 32'(exp_hi(0)));
        chk("mix_nrd", 32'(n_rd), 32'(exp_hi(1)));
        chk("mix_bal", 32'(wr_count >= rd_count && wr_count - rd_count <= 16'd8), 32'd1);
        chk("mix_level", 32'(f_cnt), 32'(wr_count - rd_count));
        wc1 = int'(wr_count);
        rc1 = int'(rd_count);
        clear_fifo();
        run("mix2", 2'b01, NOPS + 100, -1);
        chk("mix_rep_wr", 32'(wr_count), 32'(wc1));
        chk("mix_rep_rd", 32'(rd_count), 32'(rc1));

        // clean second fill-drain after a random run
        clear_fifo();
        run("fd2", 2'b00, 100, -1);
        chk("fd2_clear", 32'(first_sum), 32'd0);
        chk("fd2_data0", 32'(first_data), 32'd0);
        chk("fd2_wr", 32'(wr_count), 32'd8);
        chk("fd2_rd", 32'(rd_count), 32'd8);
        chk("fd2_err", 32'(ovf_count) + 32'(udf_count), 32'd0);
        chk("fd2_last", 32'(last_data), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
